memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Purpose: two-requester (instruction fetch, data) arbiter in front of one single-port RAM.
// Latency: a request is granted one edge after it is seen in IDLE; it completes on ramready (min 2 cycles per access).
// Backpressure: requesters see iwait/dwait high until the RAM pulses ramready for their own grant.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   iREN, iaddr               instruction read request and address
//   iload, iwait              instruction read data (valid on completion) and hold
//   dREN, dWEN, daddr, dstore data read/write request, address, write value
//   dload, dwait              data read data (valid on completion) and hold
//   ramREN, ramWEN, ramaddr,  registered RAM command, zero while idle
//   ramstore
//   ramload, ramready         RAM read data and one-cycle completion pulse
//   timeout_err               sticky flag: a grant was abandoned for lack of ramready
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        timeout_err
);

  localparam int SW = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT < 4) ? 2 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tcnt;

  logic d_req;
  logic pick_i;
  logic pick_d;
  logic i_done;
  logic d_done;
  logic expire;

  always_comb begin
    d_req  = dREN | dWEN;
    // Instruction wins when it is alone, or when data has starved it long enough.
    pick_i = iREN & (~d_req | (starve_cnt == STARVE_MAX));
    pick_d = d_req & ~pick_i;
    i_done = (state == IGRANT) & ramready;
    d_done = (state == DGRANT) & ramready;
    expire = (state != IDLE) & ~ramready & (tcnt == TCNT_LAST);
  end

  // Wait drops only in the very cycle the owner's access completes; an aborted
  // or foreign grant leaves it high.
  always_comb begin
    iwait = iREN & ~i_done;
    dwait = d_req & ~d_done;
    iload = 32'h0;
    dload = 32'h0;
    // Results for a requester that has since withdrawn are discarded.
    if (i_done && iREN) begin
      iload = ramload;
    end
    if (d_done && ramREN && dREN) begin
      dload = ramload;
    end
  end

  // The command registers double as the latched winner: address, store value
  // and access type are captured on the IDLE->grant edge and held until the
  // grant ends, so the RAM never sees requester-side changes mid-access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
      ramREN      <= 1'b0;
      ramWEN      <= 1'b0;
      ramaddr     <= 32'h0;
      ramstore    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (pick_i) begin
            state    <= IGRANT;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
            ramaddr  <= iaddr;
            ramstore <= 32'h0;
          end else if (pick_d) begin
            state   <= DGRANT;
            ramaddr <= daddr;
            // A simultaneous read and write request is treated as a write.
            if (dWEN) begin
              ramREN   <= 1'b0;
              ramWEN   <= 1'b1;
              ramstore <= dstore;
            end else begin
              ramREN   <= 1'b1;
              ramWEN   <= 1'b0;
              ramstore <= 32'h0;
            end
          end
        end
        IGRANT, DGRANT: begin
          if (ramready || expire) begin
            state    <= IDLE;
            tcnt     <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= 32'h0;
            ramstore <= 32'h0;
            if (expire) begin
              timeout_err <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          tcnt     <= '0;
          ramREN   <= 1'b0;
          ramWEN   <= 1'b0;
          ramaddr  <= 32'h0;
          ramstore <= 32'h0;
        end
      endcase

      // Counts data completions that an instruction fetch sat through; any
      // cycle without a fetch pending, or a served fetch, resets the debt.
      if (!iREN || i_done) begin
        starve_cnt <= '0;
      end else if (d_done && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule
